// File: rtl/reg_dump_reader.sv
// Debug register-file dumper: walks one read port over [FIRST_REG, LAST_REG], streams
// {addr, data} words on a valid/ready port and keeps a running XOR checksum.
module reg_dump_reader #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 5,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > (2**ADDR_W) - 1) begin : g_bad_range
        $error("reg_dump_reader: register range out of bounds");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] L_FIRST = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(LAST_REG);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] r_checksum;
    logic              w_accept;

    assign w_accept = r_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_checksum <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_cnt      <= L_FIRST;
                        r_checksum <= '0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_out_data <= rd_data;
                        r_out_addr <= r_cnt;
                        r_valid    <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    // abort beats a same-cycle handshake: the word is dropped uncounted
                    if (abort) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        r_checksum <= r_checksum ^ r_out_data;
                        r_valid    <= 1'b0;
                        if (r_cnt == L_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_addr   = r_cnt;
    assign out_valid = r_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign checksum  = r_checksum;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE) && !abort;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench: stimulus queues expected {addr,data} words from a register-file
// model; a negedge monitor pops and compares every accepted word and done pulse.
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [4:0]  rd_addr, out_addr;
    logic [63:0] rd_data, out_data, checksum;
    logic        out_valid, busy, done;

    logic        start_b = 1'b0, ready_b = 1'b0;
    logic [4:0]  rd_addr_b, out_addr_b;
    logic [63:0] rd_data_b, out_data_b, checksum_b;
    logic        out_valid_b, busy_b, done_b;

    logic [63:0] rf [32];
    bit          rdy_rand = 1'b0;
    int          checks = 0, errors = 0, done_cnt = 0;

    typedef struct packed { logic [4:0] a; logic [63:0] d; } word_t;
    word_t       q[$];
    logic [63:0] exp_cks = '0;
    bit          hold_v = 1'b0;
    logic [4:0]  hold_a;
    logic [63:0] hold_d;

    always #5 clk = ~clk;

    assign rd_data   = rf[rd_addr];
    assign rd_data_b = (rd_addr_b == 5'd3) ? 64'hDEAD : 64'h5555;

    reg_dump_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done), .checksum(checksum)
    );

    reg_dump_reader #(.DATA_W(64), .ADDR_W(5), .FIRST_REG(3), .LAST_REG(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_valid(out_valid_b), .out_ready(ready_b),
        .out_addr(out_addr_b), .out_data(out_data_b), .busy(busy_b), .done(done_b),
        .checksum(checksum_b)
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_cks = '0;
            hold_v  = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_addr", 64'(out_addr), 64'(hold_a));
                chk("hold_data", out_data, hold_d);
            end
            if (start && !abort && !busy) exp_cks = '0;
            if (out_valid && out_ready && !abort) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 64'(out_addr), 64'hFFFF);
                end else begin
                    word_t e;
                    e = q.pop_front();
                    chk("word_addr", 64'(out_addr), 64'(e.a));
                    chk("word_data", out_data, e.d);
                    exp_cks ^= e.d;
                end
            end
            if (abort && busy) q.delete();
            if (done) begin
                done_cnt++;
                chk("done_q_empty", 64'(q.size()), 64'd0);
                chk("done_checksum", checksum, exp_cks);
            end
            hold_v = out_valid && !out_ready && !abort;
            hold_a = out_addr;
            hold_d = out_data;
        end
    end

    function automatic logic [63:0] xor_range(input int lo, input int hi);
        logic [63:0] x = '0;
        for (int i = lo; i <= hi; i++) x ^= rf[i];
        return x;
    endfunction

    // called at posedge+1; returns at posedge+1 just after start was sampled
    task automatic do_start();
        for (int r = 0; r < 32; r++) q.push_back('{a: 5'(r), d: rf[r]});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit spam, output int cyc);
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
            start = spam ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (cyc > 2000) begin
                chk("done_timeout", 64'(cyc), 64'd0);
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic wait_word(input logic [4:0] a);
        int n = 0;
        while (!(out_valid && out_addr == a) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_word_timeout", 64'(n < 500), 64'd1);
    endtask

    initial begin
        int cyc, dc;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rd_addr_b", 64'(rd_addr_b), 64'd0);
        chk("rst_checksum", checksum, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed dump, full-rate sink
        rf[1] = 64'h11; rf[2] = 64'h22; rf[31] = 64'hF0;
        do_start();
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_valid_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("t1_first_valid", 64'(out_valid), 64'd1);
        chk("t1_first_addr", 64'(out_addr), 64'd0);
        wait_done(1'b0, cyc);
        chk("t1_done_latency", 64'(cyc + 1), 64'd64);
        chk("t1_checksum", checksum, 64'hC3);
        @(posedge clk); #1;
        chk("t1_idle", 64'({busy, done}), 64'd0);

        // backpressure
        rdy_rand = 1'b1;
        do_start();
        wait_done(1'b0, cyc);
        chk("t2_checksum", checksum, 64'hC3);
        @(posedge clk); #1;
        chk("t2_checksum_hold", checksum, 64'hC3);

        // random contents, starts while busy
        for (int it = 0; it < 3; it++) begin
            for (int i = 1; i < 32; i++) rf[i] = {$urandom, $urandom};
            do_start();
            wait_done(1'b1, cyc);
            chk("t5_checksum", checksum, xor_range(0, 31));
            @(posedge clk); #1;
        end
        rdy_rand = 1'b0;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("t5_start_abort_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("t5_still_idle", 64'(busy), 64'd0);

        // abort while word 10 is offered with ready high
        dc = done_cnt;
        do_start();
        wait_word(5'd10);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_valid", 64'(out_valid), 64'd0);
        chk("t4_checksum", checksum, xor_range(0, 9));
        repeat (3) @(posedge clk);
        #1;
        chk("t4_no_done", 64'(done_cnt), 64'(dc));

        // reset mid-dump
        do_start();
        wait_word(5'd17);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t6_rd_addr", 64'(rd_addr), 64'd0);
        chk("t6_outs", 64'({out_valid, busy, done}), 64'd0);
        chk("t6_out_addr", 64'(out_addr), 64'd0);
        chk("t6_out_data", out_data, 64'd0);
        chk("t6_checksum", checksum, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start();
        @(posedge clk); #1;
        chk("t6_restart_addr", 64'(out_addr), 64'd0);
        wait_done(1'b0, cyc);
        chk("t6_checksum_after", checksum, xor_range(0, 31));
        @(posedge clk); #1;

        // single-register instance
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        chk("t3_busy", 64'(busy_b), 64'd1);
        @(posedge clk); #1;
        chk("t3_valid", 64'(out_valid_b), 64'd1);
        chk("t3_addr", 64'(out_addr_b), 64'd3);
        chk("t3_data", out_data_b, 64'hDEAD);
        @(posedge clk); #1;
        chk("t3_hold_data", out_data_b, 64'hDEAD);
        ready_b = 1'b1;
        @(posedge clk); #1;
        ready_b = 1'b0;
        chk("t3_done", 64'(done_b), 64'd1);
        chk("t3_checksum", checksum_b, 64'hDEAD);
        @(posedge clk); #1;
        chk("t3_idle", 64'({busy_b, done_b, out_valid_b}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
